error_monitor: RTL and testbench
================================

Name: error_monitor

Overview:
- Sits directly downstream of the per-word error checker.
- Consumes the checker's registered error_flag, plus the same data_in stream that fed the checker.
- Counts error cycles, detects bursts of consecutive errors, and raises an alarm with an acknowledge handshake.
- Buffers the offending data words in a small capture FIFO, which firmware or a debug port drains.

Parameters:
- WIDTH, 8, data word width; must match the upstream checker.
- DEPTH, 4, capture FIFO entries; power of two, at least 2.
- CNT_W, 16, width of the total error counter.
- BURST_LEN, 3, number of consecutive error cycles that trigger the alarm; range 1..255.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- data_in  in  WIDTH  same word presented to the checker in the same cycle.
- error_flag  in  1  registered error output from the checker.
- clear  in  1  synchronous clear of counters, overflow flag and FIFO.
- alarm_ack  in  1  acknowledge for alarm.
- alarm  out  1  high while the FSM is in ALARM.
- total_cnt  out  CNT_W  saturating count of error cycles.
- run_cnt  out  8  current consecutive-error run length; saturates at BURST_LEN.
- cap_valid  out  1  FIFO not empty.
- cap_ready  in  1  consumer accepts the head entry.
- cap_data  out  WIDTH  head FIFO entry.
- cap_level  out  $clog2(DEPTH)+1  number of entries in the FIFO.
- overflow  out  1  sticky; an error word was dropped because the FIFO was full.

Behaviour:
- Reset (reset_n low, asynchronous):
  - All outputs are 0, the FSM is in IDLE, and the FIFO is empty.
  - d_q is 0.
  - Asserting reset mid-burst or mid-alarm aborts immediately; no state is retained.
- Alignment:
  - The block registers data_in into d_q every cycle.
  - error_flag high in cycle t refers to the word held in d_q in cycle t, i.e. data_in from cycle t-1.
  - d_q is the word pushed into the FIFO.
- total_cnt:
  - Increments by 1 in each cycle error_flag=1.
  - Holds at 2^CNT_W-1; it does not wrap.
- run_cnt:
  - Increments in each cycle error_flag=1, saturating at BURST_LEN.
  - Goes to 0 in any cycle error_flag=0.
- FSM states are IDLE, RUN, ALARM and COOL:
  - IDLE: error_flag=1 -> RUN. If BURST_LEN=1, go -> ALARM instead.
  - RUN: error_flag=0 -> IDLE. Reaching run_cnt+1 == BURST_LEN with error_flag=1 -> ALARM.
  - ALARM: alarm=1. alarm_ack=1 -> COOL, and alarm drops the next cycle. Errors continue to be counted and captured while in ALARM.
  - COOL: waits for error_flag=0 -> IDLE, so one continuous burst raises only one alarm.
  - alarm_ack is ignored outside ALARM.
  - alarm is registered and rises on the cycle after the BURST_LEN-th consecutive error is sampled.
- Capture FIFO:
  - Push when error_flag=1.
  - Pop when cap_valid && cap_ready.
  - Push into an empty FIFO: cap_valid=1 on the next cycle, with cap_data = the pushed word.
  - Full and push without pop: the word is dropped and overflow is set to 1.
  - Full and push with pop in the same cycle: both are accepted, cap_level is unchanged and no overflow occurs.
  - Empty and pop: the pop is ignored.
  - Read and write pointers wrap modulo DEPTH.
- clear:
  - Zeroes total_cnt, run_cnt and overflow, flushes the FIFO and returns the FSM to IDLE.
  - Overrides any increment, push or state change in the same cycle.
  - Does not touch d_q.

Optional Feature:
- Macro: ERROR_MONITOR_TIMESTAMP_EN.
- When defined:
  - Adds a 16-bit free-running cycle counter, reset to 0, wrapping at 0xFFFF.
  - Adds output port cap_ts (16 bits). Each FIFO entry stores the counter value of its push cycle; cap_ts follows cap_data.
  - clear does not reset the counter.
- When undefined: no timestamp counter, no cap_ts port, and FIFO storage is WIDTH bits per entry.

Test Plan:
1. Reset, then error_flag pulses for 2 cycles with data 0xAA on the preceding cycles (BURST_LEN=3):
   - total_cnt=2 and run_cnt returns to 0.
   - alarm stays 0.
   - FIFO holds 0xAA,0xAA and cap_level=2.
2. Hold error_flag high for 5 cycles:
   - alarm rises 1 cycle after the 3rd error and run_cnt saturates at 3.
   - Pulse alarm_ack with the flag still high: alarm falls, FSM is in COOL, and there is no re-alarm until the flag drops and a new 3-cycle burst occurs.
3. Fill the FIFO (DEPTH=4) with cap_ready=0, then apply 1 more error:
   - overflow=1, cap_level=4, and the head entry is unchanged.
   - Next, with full FIFO, error and cap_ready=1 in the same cycle: cap_level stays 4 and overflow stays 1 (sticky).
4. Preload total_cnt near the maximum using CNT_W=4:
   - 17 error cycles -> total_cnt=15 (saturated).
5. Assert clear in the same cycle as error_flag=1 while in ALARM:
   - Next cycle all counters are 0, the FIFO is empty, alarm=0, the FSM is IDLE and overflow=0.
6. Drop reset_n asynchronously mid-burst:
   - Outputs go to 0 without a clock edge.
   - With ERROR_MONITOR_TIMESTAMP_EN defined, the bench also checks that cap_ts increments by the cycle spacing between captured errors.

Source files
------------

// File: rtl/error_monitor.sv
// Error-burst monitor: counts error cycles, raises an acknowledged alarm on bursts
// and captures offending words in a small FIFO. ERROR_MONITOR_TIMESTAMP_EN adds cap_ts.
module error_monitor #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int CNT_W     = 16,
    parameter int BURST_LEN = 3
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [WIDTH-1:0]       data_in,
    input  logic                   error_flag,
    input  logic                   clear,
    input  logic                   alarm_ack,
    output logic                   alarm,
    output logic [CNT_W-1:0]       total_cnt,
    output logic [7:0]             run_cnt,
    output logic                   cap_valid,
    input  logic                   cap_ready,
    output logic [WIDTH-1:0]       cap_data,
    output logic [$clog2(DEPTH):0] cap_level,
`ifdef ERROR_MONITOR_TIMESTAMP_EN
    output logic [15:0]            cap_ts,
`endif
    output logic                   overflow
);
    localparam int AW = $clog2(DEPTH);
`ifdef ERROR_MONITOR_TIMESTAMP_EN
    localparam int EW = WIDTH + 16;
`else
    localparam int EW = WIDTH;
`endif
    localparam logic [8:0] BURST_C = 9'(BURST_LEN);

    typedef enum logic [1:0] {IDLE, RUN, ALARM, COOL} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  d_q;
    logic [CNT_W-1:0]  total_q, total_d;
    logic [7:0]        run_q, run_d;
    logic              ovf_q, ovf_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]       level_q, level_d;
    logic [EW-1:0]     mem [DEPTH];
    logic [EW-1:0]     entry, head;
    logic              full, pop_en, push_en, run_hit;

    assign full    = (level_q == (AW+1)'(DEPTH));
    assign pop_en  = (level_q != '0) && cap_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_en = error_flag && (!full || pop_en);
    assign run_hit = ({1'b0, run_q} + 9'd1) == BURST_C;

`ifdef ERROR_MONITOR_TIMESTAMP_EN
    logic [15:0] ts_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ts_q <= '0;
        else          ts_q <= ts_q + 16'd1;
    end
    assign entry  = {ts_q, d_q};
    assign cap_ts = cap_valid ? head[EW-1:WIDTH] : '0;
`else
    assign entry = d_q;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (error_flag) state_d = (BURST_LEN == 1) ? ALARM : RUN;
            RUN:     if (!error_flag) state_d = IDLE;
                     else if (run_hit) state_d = ALARM;
            ALARM:   if (alarm_ack) state_d = COOL;
            COOL:    if (!error_flag) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (clear) state_d = IDLE;
    end

    always_comb begin
        alarm = (state_q == ALARM);
    end

    always_comb begin
        total_d  = total_q;
        run_d    = '0;
        ovf_d    = ovf_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (error_flag) begin
            if (total_q != '1) total_d = total_q + CNT_W'(1);
            run_d = ({1'b0, run_q} >= BURST_C) ? run_q : run_q + 8'd1;
            if (!push_en) ovf_d = 1'b1;
        end
        if (push_en) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_en)  rd_ptr_d = rd_ptr_q + AW'(1);
        level_d = level_q + (AW+1)'(push_en) - (AW+1)'(pop_en);
        if (clear) begin
            total_d  = '0;
            run_d    = '0;
            ovf_d    = 1'b0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d_q      <= '0;
            total_q  <= '0;
            run_q    <= '0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            d_q      <= data_in;
            total_q  <= total_d;
            run_q    <= run_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en && !clear) mem[wr_ptr_q] <= entry;
    end

    assign head      = mem[rd_ptr_q];
    assign cap_valid = (level_q != '0);
    // Gate the head so an empty FIFO never exposes stale or uninitialised storage.
    assign cap_data  = cap_valid ? head[WIDTH-1:0] : '0;
    assign cap_level = level_q;
    assign total_cnt = total_q;
    assign run_cnt   = run_q;
    assign overflow  = ovf_q;
endmodule

// File: tb/tb_error_monitor.sv
// Randomised and directed bench for error_monitor against a queue-based reference
// model; a second instance with CNT_W=4 exercises counter saturation.
module tb_error_monitor;
    localparam int D  = 4;
    localparam int BL = 3;

    logic       clk = 1'b0, reset_n = 1'b0;
    logic [7:0] data_in = '0;
    logic       error_flag = 1'b0, clear = 1'b0, alarm_ack = 1'b0, cap_ready = 1'b0;

    logic        alarm, cap_valid, overflow;
    logic [15:0] total_cnt;
    logic [7:0]  run_cnt, cap_data;
    logic [2:0]  cap_level;
    logic        alarm4, cap_valid4, overflow4;
    logic [3:0]  total_cnt4;
    logic [7:0]  run_cnt4, cap_data4;
    logic [2:0]  cap_level4;
`ifdef ERROR_MONITOR_TIMESTAMP_EN
    logic [15:0] cap_ts, cap_ts4;
`endif

    error_monitor #(.WIDTH(8), .DEPTH(D), .CNT_W(16), .BURST_LEN(BL)) dut (
        .clk(clk), .reset_n(reset_n), .data_in(data_in), .error_flag(error_flag),
        .clear(clear), .alarm_ack(alarm_ack), .alarm(alarm), .total_cnt(total_cnt),
        .run_cnt(run_cnt), .cap_valid(cap_valid), .cap_ready(cap_ready),
        .cap_data(cap_data), .cap_level(cap_level),
`ifdef ERROR_MONITOR_TIMESTAMP_EN
        .cap_ts(cap_ts),
`endif
        .overflow(overflow));

    error_monitor #(.WIDTH(8), .DEPTH(D), .CNT_W(4), .BURST_LEN(BL)) dut4 (
        .clk(clk), .reset_n(reset_n), .data_in(data_in), .error_flag(error_flag),
        .clear(clear), .alarm_ack(alarm_ack), .alarm(alarm4), .total_cnt(total_cnt4),
        .run_cnt(run_cnt4), .cap_valid(cap_valid4), .cap_ready(cap_ready),
        .cap_data(cap_data4), .cap_level(cap_level4),
`ifdef ERROR_MONITOR_TIMESTAMP_EN
        .cap_ts(cap_ts4),
`endif
        .overflow(overflow4));

    always #5 clk = ~clk;

    // Reference model: unbounded counts clipped on comparison, FIFO as a queue.
    int         m_total, m_run, m_ts, checks, errors, cyc;
    bit         m_alarm, m_cool, m_ovf;
    logic [7:0] m_d;
    logic [7:0] q_data[$];
    int         q_ts[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic int clip(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        m_total = 0; m_run = 0; m_ts = 0; m_alarm = 0; m_cool = 0; m_ovf = 0; m_d = '0;
        q_data.delete(); q_ts.delete();
    endtask

    task automatic model_step();
        bit pop, full;
        if (clear) begin
            m_total = 0; m_run = 0; m_ovf = 0; m_alarm = 0; m_cool = 0;
            q_data.delete(); q_ts.delete();
        end else begin
            pop  = (q_data.size() > 0) && cap_ready;
            full = (q_data.size() == D);
            // One alarm per continuous burst; after ack wait for a quiet cycle.
            if (m_alarm) begin
                if (alarm_ack) begin m_alarm = 0; m_cool = 1; end
            end else if (m_cool) begin
                if (!error_flag) m_cool = 0;
            end else if (error_flag && (m_run + 1 >= BL)) begin
                m_alarm = 1;
            end
            m_run   = error_flag ? m_run + 1 : 0;
            m_total = m_total + int'(error_flag);
            if (pop) begin void'(q_data.pop_front()); void'(q_ts.pop_front()); end
            if (error_flag) begin
                if (full && !pop) m_ovf = 1;
                else begin q_data.push_back(m_d); q_ts.push_back(m_ts); end
            end
        end
        m_d  = data_in;
        m_ts = (m_ts + 1) % 65536;
    endtask

    task automatic check_outputs();
        logic [7:0] exp_data;
        exp_data = (q_data.size() > 0) ? q_data[0] : 8'h00;
        chk("alarm",     32'(alarm),      32'(m_alarm));
        chk("total",     32'(total_cnt),  clip(m_total, 65535));
        chk("total4",    32'(total_cnt4), clip(m_total, 15));
        chk("run",       32'(run_cnt),    clip(m_run, BL));
        chk("cap_valid", 32'(cap_valid),  32'(q_data.size() > 0));
        chk("cap_level", 32'(cap_level),  q_data.size());
        chk("cap_data",  32'(cap_data),   32'(exp_data));
        chk("overflow",  32'(overflow),   32'(m_ovf));
`ifdef ERROR_MONITOR_TIMESTAMP_EN
        chk("cap_ts",    32'(cap_ts),     (q_ts.size() > 0) ? q_ts[0] : 0);
`endif
    endtask

    task automatic step(input logic [7:0] d, input bit ef, input bit clr, input bit ack, input bit rdy);
        data_in = d; error_flag = ef; clear = clr; alarm_ack = ack; cap_ready = rdy;
        model_step();
        @(posedge clk); #1;
        cyc++;
        check_outputs();
        $display("cyc %0d d=%02h ef=%0b clr=%0b ack=%0b rdy=%0b | alarm=%0b tot=%0d tot4=%0d run=%0d lvl=%0d head=%02h ovf=%0b",
                 cyc, d, ef, clr, ack, rdy, alarm, total_cnt, total_cnt4, run_cnt, cap_level, cap_data, overflow);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_alarm"}, 32'(alarm),     0);
        chk({tag, "_total"}, 32'(total_cnt), 0);
        chk({tag, "_run"},   32'(run_cnt),   0);
        chk({tag, "_valid"}, 32'(cap_valid), 0);
        chk({tag, "_level"}, 32'(cap_level), 0);
        chk({tag, "_data"},  32'(cap_data),  0);
        chk({tag, "_ovf"},   32'(overflow),  0);
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0;
        model_reset();
        #12;
        check_zero("reset");
        reset_n = 1'b1;

        // Two-cycle error pulse on 0xAA words
        step(8'hAA, 0, 0, 0, 0);
        step(8'hAA, 1, 0, 0, 0);
        step(8'h11, 1, 0, 0, 0);
        step(8'h22, 0, 0, 0, 0);
        chk("t1_total", 32'(total_cnt), 2);
        chk("t1_run",   32'(run_cnt),   0);
        chk("t1_alarm", 32'(alarm),     0);
        chk("t1_level", 32'(cap_level), 2);
        chk("t1_head",  32'(cap_data),  32'h0AA);

        // Burst with ack while errors continue, then a fresh burst
        step(8'h30, 1, 0, 0, 1);
        step(8'h31, 1, 0, 0, 1);
        chk("t2_noalarm", 32'(alarm), 0);
        step(8'h32, 1, 0, 0, 1);
        chk("t2_alarm", 32'(alarm), 1);
        chk("t2_run",   32'(run_cnt), 3);
        step(8'h33, 1, 0, 1, 1);
        chk("t2_acked", 32'(alarm), 0);
        for (int i = 0; i < 4; i++) step(8'h40, 1, 0, 0, 1);
        chk("t2_cool", 32'(alarm), 0);
        step(8'h41, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(8'h50 + 8'(i), 1, 0, 0, 1);
        chk("t2_realarm", 32'(alarm), 1);
        step(8'h00, 0, 0, 1, 1);
        for (int i = 0; i < 5; i++) step(8'h00, 0, 0, 0, 1);
        step(8'h00, 0, 1, 0, 0);

        // Fill FIFO, overflow, then full push+pop
        step(8'hC0, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) step(8'hC0 + 8'(i), 1, 0, 0, 0);
        chk("t3_level", 32'(cap_level), 4);
        step(8'hCF, 1, 0, 0, 0);
        chk("t3_ovf",   32'(overflow),  1);
        chk("t3_full",  32'(cap_level), 4);
        chk("t3_head",  32'(cap_data),  32'h0C0);
        step(8'hD0, 1, 0, 0, 1);
        chk("t3_lvl2",  32'(cap_level), 4);
        chk("t3_ovf2",  32'(overflow),  1);
        step(8'h00, 0, 0, 1, 0);
        step(8'h00, 0, 1, 0, 0);

        // Saturation on the CNT_W=4 instance, ending in ALARM
        for (int i = 0; i < 17; i++) step(8'($urandom_range(0, 255)), 1, 0, 0, 1);
        chk("t4_sat4",  32'(total_cnt4), 15);
        chk("t4_total", 32'(total_cnt),  17);
        chk("t4_alarm", 32'(alarm),      1);

        // Clear with an error in ALARM
        step(8'h77, 1, 1, 0, 0);
        check_zero("t5");

        // Random traffic
        for (int i = 0; i < 300; i++)
            step(8'($urandom_range(0, 255)), $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 3,
                 $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 40);

        // Asynchronous reset mid-burst
        step(8'h90, 1, 0, 0, 0);
        step(8'h91, 1, 0, 0, 0);
        #3 reset_n = 1'b0;
        #1 check_zero("t6");
        @(posedge clk); #2;
        check_zero("t6_hold");
        reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < 20; i++)
            step(8'($urandom_range(0, 255)), $urandom_range(0, 99) < 50, 1'b0,
                 $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
